// File: rtl/rptr_empty_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion used by both pointer domains.
package rptr_empty_pkg;

  localparam int unsigned ADDRSIZE_DEF = 4;
  localparam int unsigned DEPTH        = 1 << ADDRSIZE_DEF;

  // Zero-extended inputs convert correctly, so callers cast narrower pointers to 32 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read-side pointer, empty/almost-empty flags and fill-level estimate for the dual-clock FIFO.
module rptr_empty
  import rptr_empty_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = ADDRSIZE_DEF,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic          rd_en;
  logic          rempty_val;
  logic          raempty_val;

  always_comb begin
    rd_en       = rinc & ~rempty;
    rbinnext    = rbin + PW'(rd_en);
    rgraynext   = PW'(bin2gray(32'(rbinnext)));
    wbin_s      = PW'(gray2bin(32'(rq2_wptr)));
    // Modular difference stays in 0..DEPTH because the writer never laps the reader.
    level_next  = wbin_s - rbinnext;
    rempty_val  = (rgraynext == rq2_wptr);
    raempty_val = rempty_val | (level_next <= AE_LVL);
  end

  // rptr feeds the read-to-write synchroniser directly, so it must stay a bare flop.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= rempty_val;
      raempty    <= raempty_val;
      rlevel     <= level_next;
      runderflow <= runderflow | (rinc & rempty);
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty.sv
// Scoreboard bench for rptr_empty: a count-based reference model predicts every cycle's outputs.
module tb_rptr_empty;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rinc = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;

  logic          rempty1, raempty1, runderflow1, rempty2, raempty2, runderflow2;
  logic [PW-1:0] rlevel1, rptr1, rlevel2, rptr2;
  logic [AW-1:0] raddr1, raddr2;

  rptr_empty #(.ADDRSIZE(AW), .AE_THRESH(1)) dut1 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rempty(rempty1), .raempty(raempty1), .rlevel(rlevel1),
    .runderflow(runderflow1), .raddr(raddr1), .rptr(rptr1)
  );

  rptr_empty #(.ADDRSIZE(AW), .AE_THRESH(2)) dut2 (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rempty(rempty2), .raempty(raempty2), .rlevel(rlevel2),
    .runderflow(runderflow2), .raddr(raddr2), .rptr(rptr2)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int unsigned raddr;
    int unsigned rptr;
    int unsigned rlevel;
    bit          rempty;
    bit          raempty1;
    bit          raempty2;
    bit          runderflow;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: counts of entries read and written since reset.
  int unsigned rd_cnt   = 0;
  int unsigned wr_cnt   = 0;
  bit          m_empty  = 1'b1;
  bit          m_uflow  = 1'b0;

  function automatic int unsigned gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: apply inputs, predict the state after the coming edge.
  task automatic step(input bit rd, input int unsigned wr, input string tag);
    exp_t e;
    int unsigned level;
    @(negedge rclk);
    rinc     = rd;
    wr_cnt   = wr;
    rq2_wptr = PW'(gray(wr_cnt % 32));
    if (rd && m_empty) m_uflow = 1'b1;
    if (rd && !m_empty) rd_cnt++;
    level        = wr_cnt - rd_cnt;
    m_empty      = (level == 0);
    e.raddr      = rd_cnt % 16;
    e.rptr       = gray(rd_cnt % 32);
    e.rlevel     = level;
    e.rempty     = m_empty;
    e.raempty1   = (level <= 1);
    e.raempty2   = (level <= 2);
    e.runderflow = m_uflow;
    e.tag        = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".raddr"},      32'(raddr1),      e.raddr);
        chk({e.tag, ".rptr"},       32'(rptr1),       e.rptr);
        chk({e.tag, ".rlevel"},     32'(rlevel1),     e.rlevel);
        chk({e.tag, ".rempty"},     32'(rempty1),     32'(e.rempty));
        chk({e.tag, ".raempty1"},   32'(raempty1),    32'(e.raempty1));
        chk({e.tag, ".runderflow"}, 32'(runderflow1), 32'(e.runderflow));
        chk({e.tag, ".raempty2"},   32'(raempty2),    32'(e.raempty2));
        chk({e.tag, ".rptr2"},      32'(rptr2),       e.rptr);
        chk({e.tag, ".rempty2"},    32'(rempty2),     32'(e.rempty));
      end
    end
  end

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic mid_reset();
    @(posedge rclk);
    #3;
    rrst     = 1'b1;
    rinc     = 1'b0;
    rq2_wptr = '0;
    #1;
    chk("rst.rptr",       32'(rptr1),       0);
    chk("rst.raddr",      32'(raddr1),      0);
    chk("rst.rempty",     32'(rempty1),     1);
    chk("rst.raempty",    32'(raempty1),    1);
    chk("rst.rlevel",     32'(rlevel1),     0);
    chk("rst.runderflow", 32'(runderflow1), 0);
    rd_cnt  = 0;
    wr_cnt  = 0;
    m_empty = 1'b1;
    m_uflow = 1'b0;
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin : stim
    int unsigned w;
    repeat (2) @(posedge rclk);
    mid_reset();

    // Drain three entries.
    step(0, 3, "drain0");
    for (int i = 0; i < 3; i++) step(1, 3, "drain");

    // Underflow: pointer holds, flag sticks until reset.
    step(1, 3, "uflow");
    step(0, 3, "uflow_hold");
    step(0, 3, "uflow_hold");
    mid_reset();

    // Full level, then a full lap so the pointer wraps to zero.
    step(0, 16, "full");
    for (int i = 0; i < 16; i++) step(1, 16, "lap1");
    step(0, 32, "full2");
    for (int i = 0; i < 16; i++) step(1, 32, "lap2");

    // Read of last entry coincides with a new write.
    step(0, 33, "simul0");
    step(1, 34, "simul");
    step(1, 34, "simul_drain");

    // Almost-empty boundaries for both thresholds.
    step(0, 39, "ae5");
    for (int i = 0; i < 6; i++) step(1, 39, "ae_read");

    // Random traffic: writer moves at most one Gray step per cycle and never laps the reader.
    w = wr_cnt;
    for (int i = 0; i < 400; i++) begin
      if (w < rd_cnt + 16 && ($urandom % 2) == 1) w++;
      step(($urandom % 3) != 0, w, "rand");
    end

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(posedge rclk);
        n++;
      end
      #2;
      if (exp_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
